// File: rtl/alu_op_issue.sv
// Issue stage for the combinational logic/shift/compare unit: a small command
// FIFO drives the unit, and a registered valid/ready stage captures its result.
module alu_op_issue #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WIDTH-1:0]        in_a,
  input  logic [WIDTH-1:0]        in_b,
  input  logic [4:0]              in_op,
  input  logic [TAG_W-1:0]        in_tag,
  output logic [WIDTH-1:0]        alu_a,
  output logic [WIDTH-1:0]        alu_b,
  output logic [4:0]              alu_op,
  input  logic [WIDTH-1:0]        alu_result,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_result,
  output logic [TAG_W-1:0]        out_tag,
  output logic                    out_illegal,
  output logic [$clog2(DEPTH):0]  fifo_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_a_q   [DEPTH];
  logic [WIDTH-1:0] mem_b_q   [DEPTH];
  logic [4:0]       mem_op_q  [DEPTH];
  logic [TAG_W-1:0] mem_tag_q [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_result_q, out_result_d;
  logic [TAG_W-1:0] out_tag_q, out_tag_d;
  logic             out_illegal_q, out_illegal_d;

  logic push, pop, empty, head_illegal;

  // Opcodes the downstream unit implements are 1..12; everything else is flagged.
  function automatic logic op_illegal(input logic [4:0] op);
    return (op == 5'd0) || (op > 5'd12);
  endfunction

  assign empty        = (cnt_q == '0);
  assign in_ready     = (cnt_q != FULL_CNT);
  assign push         = in_valid && in_ready;
  assign pop          = !empty && (!out_valid_q || out_ready);
  assign head_illegal = op_illegal(mem_op_q[rd_ptr_q]);

  // An empty FIFO presents opcode 0 so the unit idles with a zero result.
  assign alu_a  = empty ? '0 : mem_a_q[rd_ptr_q];
  assign alu_b  = empty ? '0 : mem_b_q[rd_ptr_q];
  assign alu_op = empty ? '0 : mem_op_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    cnt_d         = cnt_q;
    out_valid_d   = out_valid_q;
    out_result_d  = out_result_q;
    out_tag_d     = out_tag_q;
    out_illegal_d = out_illegal_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (push && !pop)      cnt_d = cnt_q + CNT_W'(1);
    else if (pop && !push) cnt_d = cnt_q - CNT_W'(1);
    if (pop) begin
      out_valid_d   = 1'b1;
      out_result_d  = head_illegal ? '0 : alu_result;
      out_tag_d     = mem_tag_q[rd_ptr_q];
      out_illegal_d = head_illegal;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Payload storage carries no reset; entries are only read once counted valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_a_q[wr_ptr_q]   <= in_a;
      mem_b_q[wr_ptr_q]   <= in_b;
      mem_op_q[wr_ptr_q]  <= in_op;
      mem_tag_q[wr_ptr_q] <= in_tag;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      cnt_q         <= '0;
      out_valid_q   <= 1'b0;
      out_result_q  <= '0;
      out_tag_q     <= '0;
      out_illegal_q <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      cnt_q         <= cnt_d;
      out_valid_q   <= out_valid_d;
      out_result_q  <= out_result_d;
      out_tag_q     <= out_tag_d;
      out_illegal_q <= out_illegal_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_result  = out_result_q;
  assign out_tag     = out_tag_q;
  assign out_illegal = out_illegal_q;
  assign fifo_count  = cnt_q;

endmodule
